// File: rtl/bloonstd1_key_poller.sv
// Avalon-MM read master: polls the key PIO data register every POLL_DIV cycles,
// debounces the returned bits and emits stable levels plus press/release pulses.
module bloonstd1_key_poller #(
  parameter int WIDTH        = 2,
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE_N   = 4,
  parameter int READ_LATENCY = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] keys_stable,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic             sample_valid
);

  localparam int TW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, REQ, LAT} state_t;

  state_t            state_q;
  logic              avm_read_q;
  logic [LW-1:0]     lat_q;

  logic [TW-1:0]     timer_q, timer_d;
  logic              tick;
  logic              sample_now;

  logic [WIDTH-1:0]  raw_bits;
  logic [WIDTH-1:0]  smp;
  logic [WIDTH-1:0]  stable_q, stable_d;
  logic [WIDTH-1:0]  press_q, press_d;
  logic [WIDTH-1:0]  release_q, release_d;
  logic              sv_q, sv_d;
  logic [WIDTH-1:0][3:0] cnt_q, cnt_d;

  logic              unused_rd;

  assign tick       = (timer_q == TW'(POLL_DIV - 1));
  assign sample_now = (state_q == LAT) && (lat_q == LW'(READ_LATENCY - 1));

  // Keys are normalised to 1 = pressed before they reach the debouncer.
  assign raw_bits  = avm_readdata[WIDTH-1:0];
  assign smp       = (ACTIVE_LOW != 0) ? ~raw_bits : raw_bits;
  assign unused_rd = ^avm_readdata[31:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      avm_read_q <= 1'b0;
      lat_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q    <= REQ;
            avm_read_q <= 1'b1;
          end
        end
        REQ: begin
          if (!avm_waitrequest) begin
            state_q    <= LAT;
            avm_read_q <= 1'b0;
            lat_q      <= '0;
          end
        end
        LAT: begin
          if (sample_now) begin
            state_q <= IDLE;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          avm_read_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    timer_d   = tick ? '0 : timer_q + TW'(1);
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    press_d   = '0;
    release_d = '0;
    sv_d      = 1'b0;
    if (sample_now) begin
      sv_d = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
        if (smp[i] == stable_q[i]) begin
          cnt_d[i] = 4'd0;
        end else if (cnt_q[i] + 4'd1 == 4'(DEBOUNCE_N)) begin
          // Enough consecutive disagreeing samples: commit the new level.
          stable_d[i]  = smp[i];
          cnt_d[i]     = 4'd0;
          press_d[i]   = smp[i];
          release_d[i] = ~smp[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      sv_q      <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      sv_q      <= sv_d;
    end
  end

  assign avm_address  = 2'd0;
  assign avm_read     = avm_read_q;
  assign keys_stable  = stable_q;
  assign key_press    = press_q;
  assign key_release  = release_q;
  assign sample_valid = sv_q;

endmodule

// File: tb/tb_bloonstd1_key_poller.sv
// Bench for bloonstd1_key_poller: PIO slave model, cycle-numbered reference model,
// a table of poll windows, stall / reset sequences and a randomized phase.
module tb_bloonstd1_key_poller;

  localparam int W  = 2;
  localparam int PD = 8;
  localparam int DN = 3;
  localparam int RL = 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   avm_address;
  logic         avm_read;
  logic         avm_waitrequest = 1'b0;
  logic [31:0]  avm_readdata = '0;
  logic [W-1:0] keys_stable, key_press, key_release;
  logic         sample_valid;

  always #5 clk = ~clk;

  bloonstd1_key_poller #(
    .WIDTH(W), .POLL_DIV(PD), .DEBOUNCE_N(DN), .READ_LATENCY(RL), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .keys_stable(keys_stable), .key_press(key_press), .key_release(key_release),
    .sample_valid(sample_valid)
  );

  int checks = 0;
  int errors = 0;

  // reference model state: expectations for the cycle numbered c
  int       c;
  logic     exp_rd;
  logic [1:0] exp_stable, exp_press, exp_rel;
  logic     exp_sv;
  int       dis [2];
  int       sample_due;
  logic [1:0] m_cap;

  // PIO slave state
  logic [1:0] in_port = 2'b11;
  int       data_due;
  logic [1:0] s_cap;
  int       stall_left;
  bit       rand_mode = 1'b0;

  // observed activity within a window
  int       n_reads, n_press, n_rel;
  logic [1:0] press_mask, rel_mask;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, c, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_rd = 1'b0; exp_stable = '0; exp_press = '0; exp_rel = '0; exp_sv = 1'b0;
    dis[0] = 0; dis[1] = 0;
    sample_due = -1; data_due = -1; stall_left = 0; c = 0;
  endtask

  task automatic check_outputs();
    chk("avm_read", avm_read, exp_rd);
    chk("avm_address", avm_address, 0);
    chk("keys_stable", keys_stable, exp_stable);
    chk("key_press", key_press, exp_press);
    chk("key_release", key_release, exp_rel);
    chk("sample_valid", sample_valid, exp_sv);
    n_reads += int'(avm_read);
    for (int i = 0; i < W; i++) begin
      n_press += int'(key_press[i]);
      n_rel   += int'(key_release[i]);
    end
    press_mask |= key_press;
    rel_mask   |= key_release;
  endtask

  task automatic drive_and_model();
    logic [31:0] tmp;
    logic [1:0]  s;
    bit          busy, nxt;
    tmp = $urandom();
    if (data_due == c) tmp[1:0] = s_cap;
    avm_readdata = tmp;
    if (rand_mode) avm_waitrequest = ($urandom_range(0, 2) == 0);
    else if (avm_read && stall_left > 0) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else avm_waitrequest = 1'b0;
    if (avm_read && !avm_waitrequest) begin
      s_cap = in_port;
      data_due = c + RL;
    end
    // model: one outstanding poll at a time, started by the tick at timer = PD-1
    busy = exp_rd || (sample_due >= 0);
    exp_press = '0; exp_rel = '0; exp_sv = 1'b0;
    if (sample_due == c) begin
      s = ~m_cap;
      exp_sv = 1'b1;
      for (int i = 0; i < W; i++) begin
        if (s[i] == exp_stable[i]) dis[i] = 0;
        else begin
          dis[i]++;
          if (dis[i] == DN) begin
            exp_stable[i] = s[i];
            dis[i] = 0;
            if (s[i]) exp_press[i] = 1'b1;
            else      exp_rel[i]   = 1'b1;
          end
        end
      end
      sample_due = -1;
    end
    if (exp_rd && !avm_waitrequest) begin
      m_cap = in_port;
      sample_due = c + RL;
      nxt = 1'b0;
    end else if (exp_rd) nxt = 1'b1;
    else nxt = !busy && ((c % PD) == PD - 1);
    exp_rd = nxt;
    c++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_outputs();
    drive_and_model();
  endtask

  task automatic apply_reset(bit mid_cycle);
    if (mid_cycle) begin
      #2 reset_n = 1'b0;
      #1;
      chk("arst_avm_read", avm_read, 0);
      chk("arst_keys_stable", keys_stable, 0);
      chk("arst_key_press", key_press, 0);
      chk("arst_key_release", key_release, 0);
      chk("arst_sample_valid", sample_valid, 0);
    end else reset_n = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    check_outputs();
    drive_and_model();
  endtask

  task automatic align();
    while ((c % PD) != 3) step();
  endtask

  task automatic clear_obs();
    n_reads = 0; n_press = 0; n_rel = 0; press_mask = '0; rel_mask = '0;
  endtask

  typedef struct {
    logic [1:0] in_port;
    int         polls;
    logic [1:0] stable;
    logic [1:0] pmask;
    int         pn;
    logic [1:0] rmask;
    int         rn;
  } vec_t;

  vec_t tbl [10];

  task automatic stall_seq(int stall, int exp_next);
    int  rs, len, sv_at, nxt;
    bit  prev;
    rs = -1; len = 0; sv_at = -1; nxt = -1; prev = 1'b0;
    align();
    stall_left = stall;
    for (int k = 0; k < 32; k++) begin
      step();
      if (avm_read && rs < 0) rs = c - 1;
      else if (rs >= 0 && nxt < 0 && avm_read && !prev) nxt = c - 1;
      if (avm_read && rs >= 0 && nxt < 0) len++;
      if (sample_valid && rs >= 0 && sv_at < 0) sv_at = c - 1;
      prev = avm_read;
    end
    chk("stall_read_len", len, stall + 1);
    chk("stall_sample_delay", sv_at - rs, stall + 2);
    chk("stall_next_read", nxt - rs, exp_next);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout cycle %0d", c);
    $fatal(1);
  end

  initial begin
    int first, hold_left;
    tbl[0] = '{2'b11, 5, 2'b00, 2'b00, 0, 2'b00, 0};
    tbl[1] = '{2'b10, 4, 2'b01, 2'b01, 1, 2'b00, 0};
    tbl[2] = '{2'b11, 2, 2'b01, 2'b00, 0, 2'b00, 0};
    tbl[3] = '{2'b10, 2, 2'b01, 2'b00, 0, 2'b00, 0};
    tbl[4] = '{2'b11, 2, 2'b01, 2'b00, 0, 2'b00, 0};
    tbl[5] = '{2'b10, 1, 2'b01, 2'b00, 0, 2'b00, 0};
    tbl[6] = '{2'b00, 4, 2'b11, 2'b10, 1, 2'b00, 0};
    tbl[7] = '{2'b10, 4, 2'b01, 2'b00, 0, 2'b10, 1};
    tbl[8] = '{2'b01, 4, 2'b10, 2'b10, 1, 2'b01, 1};
    tbl[9] = '{2'b11, 4, 2'b00, 2'b00, 0, 2'b10, 1};

    clear_obs();
    model_reset();
    in_port = 2'b11;
    apply_reset(1'b0);
    align();

    for (int v = 0; v < 10; v++) begin
      in_port = tbl[v].in_port;
      clear_obs();
      repeat (tbl[v].polls * PD) step();
      chk($sformatf("vec%0d_stable", v), keys_stable, tbl[v].stable);
      chk($sformatf("vec%0d_press_mask", v), press_mask, tbl[v].pmask);
      chk($sformatf("vec%0d_press_n", v), n_press, tbl[v].pn);
      chk($sformatf("vec%0d_release_mask", v), rel_mask, tbl[v].rmask);
      chk($sformatf("vec%0d_release_n", v), n_rel, tbl[v].rn);
      chk($sformatf("vec%0d_reads", v), n_reads, tbl[v].polls);
    end

    // a 5-cycle stall ends before the next tick; an 8-cycle stall swallows one
    stall_seq(5, 8);
    stall_seq(8, 16);

    rand_mode = 1'b1;
    hold_left = 0;
    for (int k = 0; k < 2500; k++) begin
      if (hold_left == 0) begin
        in_port = 2'($urandom());
        hold_left = $urandom_range(1, 60);
      end
      hold_left--;
      step();
    end
    rand_mode = 1'b0;

    // press both keys, then reset while a read is on the bus
    in_port = 2'b00;
    repeat (40) step();
    for (int k = 0; k < 20 && !avm_read; k++) step();
    chk("pre_reset_read_high", avm_read, 1);
    chk("pre_reset_stable", keys_stable, 2'b11);
    apply_reset(1'b1);
    first = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (avm_read && first < 0) first = c - 1;
    end
    chk("first_read_after_reset", first, 8);
    chk("post_reset_stable", keys_stable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
